// File: rtl/chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// chunked_serial_adder
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock with the
// inter-chunk carry held in a register. Valid/ready handshake on both sides.
//
// Optional feature macro: CHUNKED_SERIAL_ADDER_SUB_EN
//   When defined, adds input 'sub'. With sub=1 the block computes a - b
//   (adds ~b with carry-in forced to 1; cin is ignored). Timing is unchanged.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands present
//   in_ready   block idle, can accept
//   a, b       operands (WIDTH bits)
//   cin        carry-in
//   sub        subtract select (only with CHUNKED_SERIAL_ADDER_SUB_EN)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       unsigned carry-out of bit WIDTH-1
//   ovf        signed (two's-complement) overflow
//   busy       high while chunks are being added
// -----------------------------------------------------------------------------
module chunked_serial_adder #(
    parameter int WIDTH = 24,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [KW-1:0]      k_q, k_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   b_in_s;
    logic               cin_in_s;
    logic [CHUNK-1:0]   a_chunk_s, b_chunk_s;
    logic [CHUNK:0]     chunk_sum_s;
    logic               msb_cin_s;
    logic [WIDTH-1:0]   sum_next_s;

    // Operand conditioning: subtraction is a + ~b + 1.
    always_comb begin
        b_in_s   = b;
        cin_in_s = cin;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_in_s   = ~b;
            cin_in_s = 1'b1;
        end else begin
            b_in_s   = b;
            cin_in_s = cin;
        end
`endif
    end

    // Operands are shifted right each RUN cycle, so the current chunk is
    // always the low CHUNK bits; this avoids wide variable-index muxes.
    assign a_chunk_s   = a_q[CHUNK-1:0];
    assign b_chunk_s   = b_q[CHUNK-1:0];
    assign chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit of this chunk, recovered from its sum bit.
    assign msb_cin_s   = chunk_sum_s[CHUNK-1] ^ a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1];

    // New chunk enters the sum register from the top; after NCHUNK shifts
    // every chunk sits at its final position.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign sum_next_s = chunk_sum_s[CHUNK-1:0];
        end else begin : g_multi
            assign sum_next_s = {chunk_sum_s[CHUNK-1:0], sum_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: capture, per-chunk add, final flag capture.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_in_s;
                    carry_d = cin_in_s;
                    k_d     = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end else begin
                    a_d = a_q;
                end
            end
            S_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_sum_s[CHUNK];
                k_d     = k_q + KW'(1);
                sum_d   = sum_next_s;
                if (k_q == K_LAST) begin
                    cout_d = chunk_sum_s[CHUNK];
                    ovf_d  = msb_cin_s ^ chunk_sum_s[CHUNK];
                end else begin
                    cout_d = cout_q;
                end
            end
            S_DONE: begin
                sum_d = sum_q;
            end
            default: begin
                sum_d = sum_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output decode, purely from registered state.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
module tb_chunked_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // 8-bit instance
    logic       in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
    logic [7:0] a, b, sum;
    // 24-bit instance
    logic        in_valid24, in_ready24, cin24, out_valid24, out_ready24, cout24, ovf24, busy24;
    logic [23:0] a24, b24, sum24;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    logic       sub_r;
    logic       sub24;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        .sub(sub_r),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .busy(busy)
    );

    chunked_serial_adder #(.WIDTH(24), .CHUNK(2)) dut24 (
        .clk(clk), .rst(rst), .in_valid(in_valid24), .in_ready(in_ready24),
        .a(a24), .b(b24), .cin(cin24),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        .sub(sub24),
`endif
        .out_valid(out_valid24), .out_ready(out_ready24), .sum(sum24),
        .cout(cout24), .ovf(ovf24), .busy(busy24)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the 8-bit instance, result held then released.
    task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tcin, input logic [7:0] es, input logic ec, input logic eo);
        int n;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        a = ta; b = tb_; cin = tcin; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        check({tag, "_latency"}, n, 32'd4);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_done_in_ready"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    task automatic run24(input string tag, input logic [23:0] ta, input logic [23:0] tb_,
                         input logic tcin, input logic [23:0] es, input logic ec, input logic eo);
        int n;
        a24 = ta; b24 = tb_; cin24 = tcin; in_valid24 = 1'b1;
        tick;
        in_valid24 = 1'b0; a24 = 24'd0; b24 = 24'd0; cin24 = 1'b0;
        n = 0;
        while (!out_valid24 && n < 60) begin
            tick;
            n++;
        end
        check({tag, "_latency"}, n, 32'd12);
        check({tag, "_sum"}, {8'd0, sum24}, {8'd0, es});
        check({tag, "_flags"}, {30'd0, cout24, ovf24}, {30'd0, ec, eo});
        out_ready24 = 1'b1;
        tick;
        out_ready24 = 1'b0;
        check({tag, "_in_ready"}, {31'd0, in_ready24}, 32'd1);
    endtask

    initial begin
        logic [7:0] hold_sum;
        logic       seen;
        int         n;
        int         t_acc;
        int         t_prev;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] full;
        logic       mo;

        rst = 1'b1;
        in_valid = 1'b0; a = 8'd0; b = 8'd0; cin = 1'b0; out_ready = 1'b0;
        in_valid24 = 1'b0; a24 = 24'd0; b24 = 24'd0; cin24 = 1'b0; out_ready24 = 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        sub_r = 1'b0;
        sub24 = 1'b0;
`endif
        tick;
        tick;
        check("reset_ctrl", {29'd0, in_ready, out_valid, busy}, 32'b100);
        check("reset_result", {22'd0, sum, cout, ovf}, 32'd0);
        rst = 1'b0;
        tick;
        check("idle_ctrl", {29'd0, in_ready, out_valid, busy}, 32'b100);

        // Directed additions
        run8("basic", 8'h35, 8'h1C, 1'b0, 8'h51, 1'b0, 1'b0);
        run8("wrap",  8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run8("sovf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("negovf", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Backpressure: result held, new request ignored while in DONE
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        check("bp_latency", n, 32'd4);
        hold_sum = 8'h46;
        a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("bp_hold", {20'd0, sum, cout, ovf, out_valid, in_ready}, {20'd0, hold_sum, 4'b0010});
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
        tick;
        in_valid = 1'b0;
        check("bp_second_accept", {31'd0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        check("bp_second_latency", n, 32'd4);
        check("bp_second_sum", {24'd0, sum}, 32'h03);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Reset in the middle of RUN
        a = 8'h55; b = 8'h22; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_mid_ctrl", {29'd0, in_ready, out_valid, busy}, 32'b100);
        check("rst_mid_sum", {24'd0, sum}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            seen = seen | out_valid;
        end
        check("rst_mid_no_valid", {31'd0, seen}, 32'd0);
        run8("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // Back-to-back with out_ready held high
        out_ready = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            mo = (ra[7] == rb[7]) && (full[7] != ra[7]);
            a = ra; b = rb; cin = rc; in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin
                tick;
                n++;
            end
            tick;
            t_acc = cyc;
            in_valid = 1'b0;
            if (i > 0) begin
                check("b2b_spacing", t_acc - t_prev, 32'd6);
            end
            t_prev = t_acc;
            n = 0;
            while (!out_valid && n < 40) begin
                tick;
                n++;
            end
            check("b2b_latency", n, 32'd4);
            check("b2b_result", {22'd0, sum, cout, ovf}, {22'd0, full[7:0], full[8], mo});
        end
        tick;
        out_ready = 1'b0;
        check("b2b_idle", {31'd0, in_ready}, 32'd1);

        // 24-bit instance
        run24("w24_a", 24'h123456, 24'hFEDCBA, 1'b1, 24'h111111, 1'b1, 1'b0);
        run24("w24_b", 24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1);

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        sub_r = 1'b1;
        run8("sub_borrow", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run8("sub_ovf",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        sub_r = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
